// File: rtl/hazard_forward_unit.sv
// Operand-forwarding select and load-use stall detection for the EX stage of the
// RV32IF pipeline, with a saturating count of load-use stall cycles.
module hazard_forward_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        id_rs1_fp,
  input  logic        id_rs2_fp,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_fp,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_flush,
  input  logic        ext_stall,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        stall,
  output logic [31:0] stall_count
);

  // The WB entry is not stored: matches against it are covered by register-file
  // write-through, so it could never change an output.
  logic        ex_valid_q, ex_valid_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_rd_fp_q, ex_rd_fp_d;
  logic        ex_reg_write_q, ex_reg_write_d;
  logic        ex_mem_read_q, ex_mem_read_d;
  logic        mem_valid_q, mem_valid_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic        mem_rd_fp_q, mem_rd_fp_d;
  logic        mem_reg_write_q, mem_reg_write_d;
  logic [1:0]  forward_a_q, forward_a_d;
  logic [1:0]  forward_b_q, forward_b_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic rs1_hit_ex, rs2_hit_ex, rs1_hit_mem, rs2_hit_mem;
  logic issue;

  function automatic logic src_hit(input logic       e_valid,
                                   input logic       e_reg_write,
                                   input logic [4:0] e_rd,
                                   input logic       e_rd_fp,
                                   input logic [4:0] rs,
                                   input logic       rs_fp,
                                   input logic       rs_used);
    return e_valid && e_reg_write && rs_used && (e_rd == rs) && (e_rd_fp == rs_fp)
           && !(!rs_fp && (rs == 5'd0));
  endfunction

  always_comb begin
    rs1_hit_ex  = src_hit(ex_valid_q, ex_reg_write_q, ex_rd_q, ex_rd_fp_q,
                          id_rs1, id_rs1_fp, id_rs1_used);
    rs2_hit_ex  = src_hit(ex_valid_q, ex_reg_write_q, ex_rd_q, ex_rd_fp_q,
                          id_rs2, id_rs2_fp, id_rs2_used);
    rs1_hit_mem = src_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, mem_rd_fp_q,
                          id_rs1, id_rs1_fp, id_rs1_used);
    rs2_hit_mem = src_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, mem_rd_fp_q,
                          id_rs2, id_rs2_fp, id_rs2_used);

    stall = id_valid && !id_flush && ex_mem_read_q && (rs1_hit_ex || rs2_hit_ex);
    issue = id_valid && !id_flush && !stall;

    ex_valid_d      = ex_valid_q;
    ex_rd_d         = ex_rd_q;
    ex_rd_fp_d      = ex_rd_fp_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    mem_valid_d     = mem_valid_q;
    mem_rd_d        = mem_rd_q;
    mem_rd_fp_d     = mem_rd_fp_q;
    mem_reg_write_d = mem_reg_write_q;
    forward_a_d     = forward_a_q;
    forward_b_d     = forward_b_q;
    stall_count_d   = stall_count_q;

    if (!ext_stall) begin
      mem_valid_d     = ex_valid_q;
      mem_rd_d        = ex_rd_q;
      mem_rd_fp_d     = ex_rd_fp_q;
      mem_reg_write_d = ex_reg_write_q;
      ex_valid_d      = issue;
      ex_rd_d         = id_rd;
      ex_rd_fp_d      = id_rd_fp;
      ex_reg_write_d  = id_reg_write;
      ex_mem_read_d   = id_mem_read;

      forward_a_d = '0;
      forward_b_d = '0;
      if (issue) begin
        if (rs1_hit_ex)       forward_a_d = 2'd2;
        else if (rs1_hit_mem) forward_a_d = 2'd1;
        if (rs2_hit_ex)       forward_b_d = 2'd2;
        else if (rs2_hit_mem) forward_b_d = 2'd1;
      end

      if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q      <= 1'b0;
      ex_rd_q         <= '0;
      ex_rd_fp_q      <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_rd_fp_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      forward_a_q     <= '0;
      forward_b_q     <= '0;
      stall_count_q   <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rd_q         <= ex_rd_d;
      ex_rd_fp_q      <= ex_rd_fp_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_valid_q     <= mem_valid_d;
      mem_rd_q        <= mem_rd_d;
      mem_rd_fp_q     <= mem_rd_fp_d;
      mem_reg_write_q <= mem_reg_write_d;
      forward_a_q     <= forward_a_d;
      forward_b_q     <= forward_b_d;
      stall_count_q   <= stall_count_d;
    end
  end

  assign forward_a   = forward_a_q;
  assign forward_b   = forward_b_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed and randomized checks of hazard_forward_unit against an in-flight
// instruction model of the EX/MEM/WB pipeline.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rs1_fp, id_rs2_fp, id_rd_fp;
  logic        id_reg_write, id_mem_read, id_flush, ext_stall;
  logic [1:0]  forward_a, forward_b;
  logic        stall;
  logic [31:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  hazard_forward_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_fp(id_rs1_fp), .id_rs2_fp(id_rs2_fp),
    .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_flush(id_flush), .ext_stall(ext_stall),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       fp;
    logic       we;
    logic       ld;
  } instr_t;

  instr_t      pipe [3];
  logic [1:0]  exp_fa, exp_fb;
  logic [31:0] exp_cnt;
  logic        exp_stall;

  function automatic logic reads(instr_t e, logic [4:0] r, logic fp, logic used);
    if (!used || !e.v || !e.we) return 1'b0;
    if (!fp && r == 0) return 1'b0;
    return (e.rd == r) && (e.fp == fp);
  endfunction

  function automatic logic [1:0] fwd_code(logic [4:0] r, logic fp, logic used);
    if (reads(pipe[0], r, fp, used)) return 2'd2;
    if (reads(pipe[1], r, fp, used)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic model_stall();
    return id_valid && !id_flush && pipe[0].ld &&
           (reads(pipe[0], id_rs1, id_rs1_fp, id_rs1_used) ||
            reads(pipe[0], id_rs2, id_rs2_fp, id_rs2_used));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    exp_fa = 0; exp_fb = 0; exp_cnt = 0;
  endtask

  task automatic model_edge();
    instr_t nw;
    logic [1:0] ca, cb;
    if (reset) begin
      model_clear();
    end else if (!ext_stall) begin
      ca = fwd_code(id_rs1, id_rs1_fp, id_rs1_used);
      cb = fwd_code(id_rs2, id_rs2_fp, id_rs2_used);
      nw.v  = id_valid && !id_flush && !exp_stall;
      nw.rd = id_rd; nw.fp = id_rd_fp; nw.we = id_reg_write; nw.ld = id_mem_read;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nw;
      exp_fa = nw.v ? ca : 2'd0;
      exp_fb = nw.v ? cb : 2'd0;
      if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock: check combinational stall, advance the model, check registered outputs.
  task automatic step();
    #2;
    exp_stall = model_stall();
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    model_edge();
    @(posedge clk);
    #1;
    chk("forward_a", {30'b0, forward_a}, {30'b0, exp_fa});
    chk("forward_b", {30'b0, forward_b}, {30'b0, exp_fb});
    chk("stall_count", stall_count, exp_cnt);
  endtask

  task automatic set_id(input logic v,
                        input logic [4:0] r1, input logic u1, input logic f1,
                        input logic [4:0] r2, input logic u2, input logic f2,
                        input logic [4:0] rd, input logic rdf, input logic we,
                        input logic ld);
    id_valid = v;
    id_rs1 = r1; id_rs1_used = u1; id_rs1_fp = f1;
    id_rs2 = r2; id_rs2_used = u2; id_rs2_fp = f2;
    id_rd = rd; id_rd_fp = rdf; id_reg_write = we; id_mem_read = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] cnt_save;
  logic        hold;

  initial begin
    reset = 1'b1; ext_stall = 1'b0; id_flush = 1'b0;
    nop();
    @(posedge clk); #1;
    model_clear();
    step();
    chk("reset_fa", {30'b0, forward_a}, 32'd0);
    chk("reset_cnt", stall_count, 32'd0);
    reset = 1'b0;

    // ADD x5 then dependent ADD reading x5 on rs1
    set_id(1, 5'd1, 1, 0, 5'd2, 1, 0, 5'd5, 0, 1, 0); step();
    set_id(1, 5'd5, 1, 0, 5'd6, 1, 0, 5'd9, 0, 1, 0); step();
    chk("ex_fwd_a", {30'b0, forward_a}, 32'd2);
    chk("ex_fwd_b", {30'b0, forward_b}, 32'd0);

    // ADD x5, NOP, reader on rs2
    set_id(1, 5'd1, 1, 0, 5'd2, 1, 0, 5'd5, 0, 1, 0); step();
    nop(); step();
    set_id(1, 5'd3, 1, 0, 5'd5, 1, 0, 5'd10, 0, 1, 0); step();
    chk("mem_fwd_b", {30'b0, forward_b}, 32'd1);

    // Two writes of x5 back-to-back: newest wins
    set_id(1, 5'd1, 1, 0, 5'd2, 1, 0, 5'd5, 0, 1, 0); step();
    set_id(1, 5'd1, 1, 0, 5'd2, 1, 0, 5'd5, 0, 1, 0); step();
    set_id(1, 5'd5, 1, 0, 5'd0, 0, 0, 5'd11, 0, 1, 0); step();
    chk("newest_wins", {30'b0, forward_a}, 32'd2);

    // LW x7 then reader on rs1: one stall, bubble, then code 1
    set_id(1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd7, 0, 1, 1); step();
    set_id(1, 5'd7, 1, 0, 5'd4, 1, 0, 5'd12, 0, 1, 0); step();
    chk("lu_bubble_a", {30'b0, forward_a}, 32'd0);
    #2 chk("lu_stall_once", {31'b0, stall}, 32'd0);
    step();
    chk("lu_fwd_a", {30'b0, forward_a}, 32'd1);
    chk("lu_count", stall_count, 32'd1);

    // x0 writer then x0 reader
    set_id(1, 5'd1, 1, 0, 5'd2, 1, 0, 5'd0, 0, 1, 0); step();
    set_id(1, 5'd0, 1, 0, 5'd0, 1, 0, 5'd13, 0, 1, 0); step();
    chk("x0_fwd_a", {30'b0, forward_a}, 32'd0);
    // FLW f0, NOP, FADD reading f0
    set_id(1, 5'd1, 1, 0, 5'd0, 0, 0, 5'd0, 1, 1, 1); step();
    nop(); step();
    set_id(1, 5'd0, 1, 1, 5'd1, 1, 1, 5'd2, 1, 1, 0); step();
    chk("f0_fwd_a", {30'b0, forward_a}, 32'd1);
    // integer x3 writer, f3 reader
    set_id(1, 5'd1, 1, 0, 5'd2, 1, 0, 5'd3, 0, 1, 0); step();
    set_id(1, 5'd3, 1, 1, 5'd3, 1, 1, 5'd4, 1, 1, 0); step();
    chk("file_mismatch", {30'b0, forward_a}, 32'd0);

    // Load-use hazard killed by flush
    set_id(1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd7, 0, 1, 1); step();
    cnt_save = stall_count;
    set_id(1, 5'd7, 1, 0, 5'd7, 1, 0, 5'd12, 0, 1, 0);
    id_flush = 1'b1;
    #2 chk("flush_no_stall", {31'b0, stall}, 32'd0);
    step();
    id_flush = 1'b0;
    chk("flush_fwd_a", {30'b0, forward_a}, 32'd0);
    chk("flush_cnt", stall_count, cnt_save);

    // Hazard held under ext_stall for 3 cycles
    set_id(1, 5'd2, 1, 0, 5'd0, 0, 0, 5'd7, 0, 1, 1); step();
    cnt_save = stall_count;
    set_id(1, 5'd7, 1, 0, 5'd4, 1, 0, 5'd12, 0, 1, 0);
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("ext_hold_cnt", stall_count, cnt_save);
    ext_stall = 1'b0;
    step();
    chk("ext_release_cnt", stall_count, cnt_save + 32'd1);
    step();
    chk("ext_release_fwd", {30'b0, forward_a}, 32'd1);

    // Reset mid-sequence
    set_id(1, 5'd1, 1, 0, 5'd2, 1, 0, 5'd5, 0, 1, 0); step();
    set_id(1, 5'd5, 1, 0, 5'd5, 1, 0, 5'd6, 0, 1, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_reset_fa", {30'b0, forward_a}, 32'd0);
    chk("mid_reset_cnt", stall_count, 32'd0);

    // Randomized traffic; upstream holds ID while frozen or stalled
    hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        set_id($urandom_range(0, 9) != 0,
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
               5'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, 1'b1,
               $urandom_range(0, 2) == 0);
        if ($urandom_range(0, 5) == 0) id_reg_write = 1'b0;
        if (!id_reg_write) id_mem_read = 1'b0;
        id_flush = $urandom_range(0, 9) == 0;
      end
      if (!ext_stall || $urandom_range(0, 2) == 0) ext_stall = $urandom_range(0, 5) == 0;
      reset = $urandom_range(0, 79) == 0;
      step();
      hold = !reset && (ext_stall || exp_stall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
